// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared types and constants for the ID/EX control-bundle stage
package ctrl_pkg;

    localparam int CTRL_W = 8;

    typedef struct packed {
        logic       regWrite;
        logic       aluSrc;
        logic [1:0] writeSrc;
        logic [1:0] aluOp;
        logic       memRead;
        logic       memWrite;
    } ctrl_t;

    localparam int REG_WRITE_BIT = 7;
    localparam int ALU_SRC_BIT   = 6;
    localparam int WRITE_SRC_LSB = 4;
    localparam int ALU_OP_LSB    = 2;
    localparam int MEM_READ_BIT  = 1;
    localparam int MEM_WRITE_BIT = 0;

    localparam logic [CTRL_W-1:0] DEFAULT_KILL_MASK = {CTRL_W{1'b1}};

    typedef enum logic {
        IDLE   = 1'b0,
        BUBBLE = 1'b1
    } bubble_state_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - synchronous-clear saturating up-counter
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    always_ff @(posedge clk) begin
        if (clr_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != {W{1'b1}})) begin
            cnt_o <= cnt_o + W'(1);
        end
    end

endmodule

// File: rtl/ctrl_bubble_stage.sv
// rtl/ctrl_bubble_stage.sv - ID/EX control register with flush, stall and multi-cycle bubble insertion
module ctrl_bubble_stage
    import ctrl_pkg::*;
#(
    parameter int                CTRL_W     = ctrl_pkg::CTRL_W,
    parameter logic [CTRL_W-1:0] KILL_MASK  = {CTRL_W{1'b1}},
    parameter int                MAX_BUBBLE = 3,
    parameter int                CNT_W      = $clog2(MAX_BUBBLE + 1),
    parameter int                PERF_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic              valid_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              bubble_req_i,
    input  logic [CNT_W-1:0]  bubble_len_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic              valid_o,
    output logic              stall_o,
    output logic              busy_o,
    output logic [PERF_W-1:0] bubble_cnt_o
);

    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_BUBBLE);

    bubble_state_e     state;
    logic [CNT_W-1:0]  downCnt;
    logic [CNT_W-1:0]  runLen;
    logic [CTRL_W-1:0] bubbleVal;
    logic              reqActive;
    logic              bubbleInc;

    assign runLen    = (bubble_len_i > MAX_LEN) ? MAX_LEN : bubble_len_i;
    assign reqActive = bubble_req_i && (bubble_len_i != '0);
    assign bubbleVal = ctrl_i & ~KILL_MASK;

    // Hold upstream for every cycle a bubble is being issued, including the request cycle.
    assign stall_o   = !flush_i && ((state == BUBBLE) || ((state == IDLE) && reqActive));
    assign bubbleInc = !flush_i && !stall_i && ((state == BUBBLE) || reqActive);
    assign busy_o    = (state == BUBBLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_o  <= '0;
            valid_o <= 1'b0;
            state   <= IDLE;
            downCnt <= '0;
        end else if (flush_i) begin
            ctrl_o  <= bubbleVal;
            valid_o <= 1'b0;
            state   <= IDLE;
            downCnt <= '0;
        end else if (stall_i) begin
            ctrl_o  <= ctrl_o;
            valid_o <= valid_o;
        end else if (state == BUBBLE) begin
            ctrl_o  <= bubbleVal;
            valid_o <= 1'b0;
            downCnt <= downCnt - CNT_W'(1);
            if (downCnt == CNT_W'(1)) begin
                state <= IDLE;
            end
        end else if (reqActive) begin
            ctrl_o  <= bubbleVal;
            valid_o <= 1'b0;
            // The request cycle itself is the first bubble; only the remainder needs the FSM.
            if (runLen > CNT_W'(1)) begin
                state   <= BUBBLE;
                downCnt <= runLen - CNT_W'(1);
            end
        end else begin
            ctrl_o  <= ctrl_i;
            valid_o <= valid_i;
        end
    end

    sat_counter #(
        .W(PERF_W)
    ) u_bubble_cnt (
        .clk  (clk),
        .inc_i(bubbleInc),
        .clr_i(rst),
        .cnt_o(bubble_cnt_o)
    );

endmodule

// File: tb/tb_ctrl_bubble_stage.sv
// tb/tb_ctrl_bubble_stage.sv - self-checking bench for ctrl_bubble_stage
module tb_ctrl_bubble_stage;

    typedef struct {
        logic [7:0] c;
        logic       v;
        logic       st;
        logic       fl;
        logic       br;
        logic [2:0] len;
        logic       eStall;
        logic [7:0] eCtrl;
        logic       eValid;
        logic       eBusy;
    } row_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ctrlI;
    logic       validI, stallI, flushI, reqI;
    logic [2:0] lenI;

    logic [7:0]  aCtrl, bCtrl;
    logic        aValid, aStall, aBusy, bValid, bStall, bBusy;
    logic [31:0] aCnt;
    logic [3:0]  bCnt;

    int   errors = 0;
    int   checks = 0;
    row_t sbq[$];

    always #5 clk = ~clk;

    ctrl_bubble_stage #(
        .CTRL_W(8), .KILL_MASK(8'hFF), .MAX_BUBBLE(3), .CNT_W(3), .PERF_W(32)
    ) dutA (
        .clk(clk), .rst(rst), .ctrl_i(ctrlI), .valid_i(validI), .stall_i(stallI),
        .flush_i(flushI), .bubble_req_i(reqI), .bubble_len_i(lenI),
        .ctrl_o(aCtrl), .valid_o(aValid), .stall_o(aStall), .busy_o(aBusy), .bubble_cnt_o(aCnt)
    );

    ctrl_bubble_stage #(
        .CTRL_W(8), .KILL_MASK(8'hC3), .MAX_BUBBLE(3), .PERF_W(4)
    ) dutB (
        .clk(clk), .rst(rst), .ctrl_i(ctrlI), .valid_i(validI), .stall_i(stallI),
        .flush_i(flushI), .bubble_req_i(reqI), .bubble_len_i(lenI[1:0]),
        .ctrl_o(bCtrl), .valid_o(bValid), .stall_o(bStall), .busy_o(bBusy), .bubble_cnt_o(bCnt)
    );

    task automatic drive(input row_t r);
        ctrlI  = r.c;
        validI = r.v;
        stallI = r.st;
        flushI = r.fl;
        reqI   = r.br;
        lenI   = r.len;
    endtask

    task automatic test_reset();
        rst = 1'b1; ctrlI = 8'hA5; validI = 1'b1; stallI = 1'b0; flushI = 1'b0; reqI = 1'b1; lenI = 3'd3;
        @(posedge clk); #1;
        rst = 1'b0; reqI = 1'b0; lenI = 3'd0; validI = 1'b0;
        #1;
        checks++;
        if ({aCtrl, aValid, aBusy, aStall} !== {8'h00, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset outputs: got ctrl=%h valid=%b busy=%b stall=%b expected 00 0 0 0", aCtrl, aValid, aBusy, aStall);
        end
        checks++;
        if (aCnt !== 32'd0) begin
            errors++;
            $display("FAIL reset bubble_cnt: got %0d expected 0", aCnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_normal_stall();
        row_t rows[5] = '{
            '{8'hA5, 1, 0, 0, 0, 0, 0, 8'hA5, 1, 0},
            '{8'h3C, 0, 0, 0, 0, 0, 0, 8'h3C, 0, 0},
            '{8'h11, 1, 1, 0, 0, 0, 0, 8'h3C, 0, 0},
            '{8'h11, 1, 1, 0, 1, 2, 1, 8'h3C, 0, 0},
            '{8'h11, 1, 0, 0, 0, 0, 0, 8'h11, 1, 0}
        };
        row_t e;
        foreach (rows[i]) begin
            drive(rows[i]); sbq.push_back(rows[i]); #1;
            checks++;
            if (aStall !== rows[i].eStall) begin
                errors++;
                $display("FAIL normal stall_o row%0d: got %b expected %b", i, aStall, rows[i].eStall);
            end
            @(posedge clk); #1; e = sbq.pop_front();
            checks++;
            if ({aCtrl, aValid, aBusy} !== {e.eCtrl, e.eValid, e.eBusy}) begin
                errors++;
                $display("FAIL normal out row%0d: got %h/%b/%b expected %h/%b/%b", i, aCtrl, aValid, aBusy, e.eCtrl, e.eValid, e.eBusy);
            end
        end
        checks++;
        if (aCnt !== 32'd0) begin
            errors++;
            $display("FAIL normal bubble_cnt: got %0d expected 0", aCnt);
        end
    endtask

    task automatic test_bubble_run();
        row_t rows[4] = '{
            '{8'hFF, 1, 0, 0, 1, 3, 1, 8'h00, 0, 1},
            '{8'hFF, 1, 0, 0, 1, 3, 1, 8'h00, 0, 1},
            '{8'hFF, 1, 0, 0, 1, 3, 1, 8'h00, 0, 0},
            '{8'hFF, 1, 0, 0, 0, 0, 0, 8'hFF, 1, 0}
        };
        row_t e;
        foreach (rows[i]) begin
            drive(rows[i]); sbq.push_back(rows[i]); #1;
            checks++;
            if (aStall !== rows[i].eStall) begin
                errors++;
                $display("FAIL run stall_o row%0d: got %b expected %b", i, aStall, rows[i].eStall);
            end
            @(posedge clk); #1; e = sbq.pop_front();
            checks++;
            if ({aCtrl, aValid, aBusy} !== {e.eCtrl, e.eValid, e.eBusy}) begin
                errors++;
                $display("FAIL run out row%0d: got %h/%b/%b expected %h/%b/%b", i, aCtrl, aValid, aBusy, e.eCtrl, e.eValid, e.eBusy);
            end
        end
        checks++;
        if (aCnt !== 32'd3) begin
            errors++;
            $display("FAIL run bubble_cnt: got %0d expected 3", aCnt);
        end
    endtask

    task automatic test_stall_mid_run();
        row_t rows[6] = '{
            '{8'hC6, 1, 0, 0, 1, 3, 1, 8'h00, 0, 1},
            '{8'hC6, 1, 1, 0, 0, 0, 1, 8'h00, 0, 1},
            '{8'hC6, 1, 1, 0, 0, 0, 1, 8'h00, 0, 1},
            '{8'hC6, 1, 0, 0, 0, 0, 1, 8'h00, 0, 1},
            '{8'hC6, 1, 0, 0, 0, 0, 1, 8'h00, 0, 0},
            '{8'hC6, 1, 0, 0, 0, 0, 0, 8'hC6, 1, 0}
        };
        row_t e;
        foreach (rows[i]) begin
            drive(rows[i]); sbq.push_back(rows[i]); #1;
            checks++;
            if (aStall !== rows[i].eStall) begin
                errors++;
                $display("FAIL midstall stall_o row%0d: got %b expected %b", i, aStall, rows[i].eStall);
            end
            @(posedge clk); #1; e = sbq.pop_front();
            checks++;
            if ({aCtrl, aValid, aBusy} !== {e.eCtrl, e.eValid, e.eBusy}) begin
                errors++;
                $display("FAIL midstall out row%0d: got %h/%b/%b expected %h/%b/%b", i, aCtrl, aValid, aBusy, e.eCtrl, e.eValid, e.eBusy);
            end
            if (i == 2) begin
                checks++;
                if (aCnt !== 32'd4) begin
                    errors++;
                    $display("FAIL midstall frozen bubble_cnt: got %0d expected 4", aCnt);
                end
            end
        end
        checks++;
        if (aCnt !== 32'd6) begin
            errors++;
            $display("FAIL midstall bubble_cnt: got %0d expected 6", aCnt);
        end
    endtask

    task automatic test_flush();
        row_t rows[6] = '{
            '{8'h77, 1, 0, 0, 1, 2, 1, 8'h00, 0, 1},
            '{8'h77, 1, 0, 1, 0, 0, 0, 8'h00, 0, 0},
            '{8'h5A, 1, 0, 0, 0, 0, 0, 8'h5A, 1, 0},
            '{8'hE1, 1, 0, 1, 1, 3, 0, 8'h00, 0, 0},
            '{8'h66, 1, 0, 0, 0, 0, 0, 8'h66, 1, 0},
            '{8'h9C, 1, 1, 1, 0, 0, 0, 8'h00, 0, 0}
        };
        row_t e;
        foreach (rows[i]) begin
            drive(rows[i]); sbq.push_back(rows[i]); #1;
            checks++;
            if (aStall !== rows[i].eStall) begin
                errors++;
                $display("FAIL flush stall_o row%0d: got %b expected %b", i, aStall, rows[i].eStall);
            end
            @(posedge clk); #1; e = sbq.pop_front();
            checks++;
            if ({aCtrl, aValid, aBusy} !== {e.eCtrl, e.eValid, e.eBusy}) begin
                errors++;
                $display("FAIL flush out row%0d: got %h/%b/%b expected %h/%b/%b", i, aCtrl, aValid, aBusy, e.eCtrl, e.eValid, e.eBusy);
            end
        end
        checks++;
        if (aCnt !== 32'd7) begin
            errors++;
            $display("FAIL flush bubble_cnt: got %0d expected 7", aCnt);
        end
    endtask

    task automatic test_clamp();
        row_t rows[7] = '{
            '{8'h81, 1, 0, 0, 1, 7, 1, 8'h00, 0, 1},
            '{8'h81, 1, 0, 0, 0, 0, 1, 8'h00, 0, 1},
            '{8'h81, 1, 0, 0, 0, 0, 1, 8'h00, 0, 0},
            '{8'h81, 1, 0, 0, 0, 0, 0, 8'h81, 1, 0},
            '{8'h77, 1, 0, 0, 1, 0, 0, 8'h77, 1, 0},
            '{8'h2B, 0, 0, 0, 1, 1, 1, 8'h00, 0, 0},
            '{8'h2B, 0, 0, 0, 0, 0, 0, 8'h2B, 0, 0}
        };
        row_t e;
        foreach (rows[i]) begin
            drive(rows[i]); sbq.push_back(rows[i]); #1;
            checks++;
            if (aStall !== rows[i].eStall) begin
                errors++;
                $display("FAIL clamp stall_o row%0d: got %b expected %b", i, aStall, rows[i].eStall);
            end
            @(posedge clk); #1; e = sbq.pop_front();
            checks++;
            if ({aCtrl, aValid, aBusy} !== {e.eCtrl, e.eValid, e.eBusy}) begin
                errors++;
                $display("FAIL clamp out row%0d: got %h/%b/%b expected %h/%b/%b", i, aCtrl, aValid, aBusy, e.eCtrl, e.eValid, e.eBusy);
            end
        end
        checks++;
        if (aCnt !== 32'd11) begin
            errors++;
            $display("FAIL clamp bubble_cnt: got %0d expected 11", aCnt);
        end
    endtask

    task automatic test_reset_mid_run();
        ctrlI = 8'hF0; validI = 1'b1; stallI = 1'b0; flushI = 1'b0; reqI = 1'b1; lenI = 3'd3;
        @(posedge clk); #1;
        reqI = 1'b0; lenI = 3'd0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({aCtrl, aValid, aBusy, aStall} !== {8'h00, 1'b0, 1'b0, 1'b0} || aCnt !== 32'd0) begin
            errors++;
            $display("FAIL midreset outputs: got %h/%b/%b/%b cnt=%0d expected 00/0/0/0 cnt=0", aCtrl, aValid, aBusy, aStall, aCnt);
        end
        ctrlI = 8'h42;
        @(posedge clk); #1;
        checks++;
        if ({aCtrl, aValid} !== {8'h42, 1'b1}) begin
            errors++;
            $display("FAIL midreset reload: got %h/%b expected 42/1", aCtrl, aValid);
        end
    endtask

    task automatic test_kill_mask_sat();
        int expB;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            ctrlI = 8'hFF; validI = 1'b1; stallI = 1'b0; flushI = 1'b0; reqI = 1'b1; lenI = 3'd1;
            #1;
            checks++;
            if (aStall !== 1'b1) begin
                errors++;
                $display("FAIL sat stall_o iter%0d: got %b expected 1", i, aStall);
            end
            @(posedge clk); #1;
            expB = (i + 1 > 15) ? 15 : i + 1;
            checks++;
            if ({bCtrl, bValid, aCtrl, aBusy} !== {8'h3C, 1'b0, 8'h00, 1'b0} || bCnt !== 4'(expB)) begin
                errors++;
                $display("FAIL sat iter%0d: got bctrl=%h bvalid=%b actrl=%h abusy=%b bcnt=%0d expected 3c 0 00 0 %0d",
                         i, bCtrl, bValid, aCtrl, aBusy, bCnt, expB);
            end
        end
        checks++;
        if (aCnt !== 32'd20 || bCnt !== 4'hF) begin
            errors++;
            $display("FAIL sat final counts: got a=%0d b=%0d expected a=20 b=15", aCnt, bCnt);
        end
        reqI = 1'b0; lenI = 3'd0;
    endtask

    initial begin
        rst = 1'b1; ctrlI = '0; validI = 1'b0; stallI = 1'b0; flushI = 1'b0; reqI = 1'b0; lenI = '0;
        @(posedge clk); #1;
        test_reset();
        test_normal_stall();
        test_bubble_run();
        test_stall_mid_run();
        test_flush();
        test_clamp();
        test_reset_mid_run();
        test_kill_mask_sat();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
